// File: rtl/tmc4671_cmd_sequencer.sv
// Command stage in front of the TMC4671 SPI master: queues host register
// accesses, interleaves periodic poll reads and runs one SPI transfer at a time.
module tmc4671_cmd_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int POLL_PERIOD    = 1000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_address,
  input  logic        cmd_write,
  input  logic [31:0] cmd_data,
  input  logic        poll_enable,
  input  logic [6:0]  poll_address,
  output logic        rsp_valid,
  output logic [6:0]  rsp_address,
  output logic [31:0] rsp_data,
  output logic        rsp_is_poll,
  output logic        busy,
  output logic        timeout_err,
  output logic        spi_transmit,
  output logic [6:0]  spi_address,
  output logic        spi_writeNOTread,
  output logic [31:0] spi_data_in,
  input  logic [31:0] spi_data_out,
  input  logic        spi_done,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [39:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] poll_cnt;
  logic          poll_pending;
  logic [TW-1:0] tcnt;
  logic          seen_low;
  logic          cur_is_poll;
  logic          push;
  logic          pop;
  logic          take_poll;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready depends only on the registered count.
  assign cmd_ready = (count != CW'(FIFO_DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign take_poll = (state == S_IDLE) & poll_pending;
  assign pop       = (state == S_IDLE) & ~poll_pending & (count != '0);
  assign busy      = (state != S_IDLE) | (count != '0);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_address, cmd_write, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      poll_cnt         <= '0;
      poll_pending     <= 1'b0;
      state            <= S_IDLE;
      tcnt             <= '0;
      seen_low         <= 1'b0;
      cur_is_poll      <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_address      <= '0;
      rsp_data         <= '0;
      rsp_is_poll      <= 1'b0;
      timeout_err      <= 1'b0;
      spi_transmit     <= 1'b0;
      spi_address      <= '0;
      spi_writeNOTread <= 1'b0;
      spi_data_in      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A wrap in the same cycle as a poll launch re-arms the flag.
      if (!poll_enable) begin
        poll_cnt     <= '0;
        poll_pending <= 1'b0;
      end else if (poll_cnt == PW'(POLL_PERIOD - 1)) begin
        poll_cnt     <= '0;
        poll_pending <= 1'b1;
      end else begin
        poll_cnt <= poll_cnt + 1'b1;
        if (take_poll) poll_pending <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (take_poll) begin
            spi_address      <= poll_address;
            spi_writeNOTread <= 1'b0;
            spi_data_in      <= '0;
            cur_is_poll      <= 1'b1;
            spi_transmit     <= 1'b1;
            state            <= S_LAUNCH;
          end else if (pop) begin
            {spi_address, spi_writeNOTread, spi_data_in} <= fifo_mem[rd_ptr];
            cur_is_poll  <= 1'b0;
            spi_transmit <= 1'b1;
            state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          spi_transmit <= 1'b0;
          seen_low     <= 1'b0;
          tcnt         <= '0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          // A done level still high from the previous transfer must drop first.
          if (!spi_done) seen_low <= 1'b1;
          if (spi_done && seen_low) begin
            if (!spi_writeNOTread) begin
              rsp_address <= spi_address;
              rsp_data    <= spi_data_out;
              rsp_is_poll <= cur_is_poll;
              rsp_valid   <= 1'b1;
              state       <= S_RESP;
            end else begin
              state <= S_IDLE;
            end
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
